// File: rtl/iob_fifo2axis.sv
// iob_fifo2axis
// Drains a programmed number of words from a synchronous FIFO read port and
// presents them as an AXI-Stream master. A 2-entry output buffer hides the
// FIFO's 1-cycle read latency so the stream can move one word per cycle.
//
// State table:
//   IDLE | waiting for en_i with a non-zero len_i
//   RUN  | fetching from the FIFO and streaming; leaves on the last handshake
//
// Ports:
//   clk_i, arst_i             clock, asynchronous active-high reset
//   cke_i                     clock enable (all state holds when low)
//   rst_i                     synchronous soft reset
//   en_i, len_i               start / fetch enable, words per transfer
//   fifo_r_en_o               FIFO read enable
//   fifo_r_data_i             FIFO read data (valid 1 cycle after read enable)
//   fifo_empty_i              FIFO empty flag
//   axis_tvalid_o/tdata_o/tlast_o, axis_tready_i   stream master
//   busy_o                    transfer in progress
//   done_o                    pulse on the last-word handshake
module iob_fifo2axis #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              cke_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              fifo_r_en_o,
   input  logic [DATA_W-1:0] fifo_r_data_i,
   input  logic              fifo_empty_i,
   output logic              axis_tvalid_o,
   output logic [DATA_W-1:0] axis_tdata_o,
   input  logic              axis_tready_i,
   output logic              axis_tlast_o,
   output logic              busy_o,
   output logic              done_o
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  fetch_cnt_q, fetch_cnt_d;
   logic [LEN_W-1:0]  send_cnt_q, send_cnt_d;
   logic [DATA_W-1:0] buf0_q, buf0_d;
   logic [DATA_W-1:0] buf1_q, buf1_d;
   logic [1:0]        buf_cnt_q, buf_cnt_d;
   logic              inflight_q, inflight_d;

   logic              accept;
   logic              last_word;
   logic              rd_en;
   logic [1:0]        occ;

   assign axis_tvalid_o = (buf_cnt_q != 2'd0);
   assign axis_tdata_o  = buf0_q;
   assign last_word     = (send_cnt_q == LEN_W'(1));
   assign axis_tlast_o  = axis_tvalid_o & last_word;
   assign busy_o        = (state_q == RUN);

   // A handshake only counts while the block is clocked and not being reset;
   // the downstream consumer shares cke_i and must qualify with it as well.
   assign accept = axis_tvalid_o & axis_tready_i & cke_i & ~rst_i;
   assign done_o = accept & last_word;

   // Words buffered plus the read still in flight; never exceeds 2.
   assign occ = buf_cnt_q + {1'b0, inflight_q};

   // A pop in this cycle frees a slot, so a full buffer can still issue a read
   // and keep the stream at one word per cycle.
   assign rd_en = cke_i & ~rst_i & (state_q == RUN) & en_i & ~fifo_empty_i &
                  (fetch_cnt_q != '0) & ((occ < 2'd2) | accept);
   assign fifo_r_en_o = rd_en;

   always_comb begin
      state_d     = state_q;
      fetch_cnt_d = fetch_cnt_q;
      send_cnt_d  = send_cnt_q;
      buf0_d      = buf0_q;
      buf1_d      = buf1_q;
      buf_cnt_d   = buf_cnt_q;
      inflight_d  = rd_en;

      case (state_q)
         IDLE: begin
            if (en_i && (len_i != '0)) begin
               state_d     = RUN;
               fetch_cnt_d = len_i;
               send_cnt_d  = len_i;
            end
         end
         RUN: begin
            if (rd_en) fetch_cnt_d = fetch_cnt_q - LEN_W'(1);
            if (accept) begin
               send_cnt_d = send_cnt_q - LEN_W'(1);
               if (last_word) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // buf0 is the head; a push with a simultaneous pop keeps arrival order.
      case ({inflight_q, accept})
         2'b10: begin
            if (buf_cnt_q == 2'd0) buf0_d = fifo_r_data_i;
            else                   buf1_d = fifo_r_data_i;
            buf_cnt_d = buf_cnt_q + 2'd1;
         end
         2'b01: begin
            buf0_d    = buf1_q;
            buf_cnt_d = buf_cnt_q - 2'd1;
         end
         2'b11: begin
            if (buf_cnt_q == 2'd1) begin
               buf0_d = fifo_r_data_i;
            end else begin
               buf0_d = buf1_q;
               buf1_d = fifo_r_data_i;
            end
         end
         default: ;
      endcase
   end

   // In-flight read data is simply dropped by a soft reset.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q     <= IDLE;
         fetch_cnt_q <= '0;
         send_cnt_q  <= '0;
         buf0_q      <= '0;
         buf1_q      <= '0;
         buf_cnt_q   <= 2'd0;
         inflight_q  <= 1'b0;
      end else if (rst_i) begin
         state_q     <= IDLE;
         fetch_cnt_q <= '0;
         send_cnt_q  <= '0;
         buf0_q      <= '0;
         buf1_q      <= '0;
         buf_cnt_q   <= 2'd0;
         inflight_q  <= 1'b0;
      end else if (cke_i) begin
         state_q     <= state_d;
         fetch_cnt_q <= fetch_cnt_d;
         send_cnt_q  <= send_cnt_d;
         buf0_q      <= buf0_d;
         buf1_q      <= buf1_d;
         buf_cnt_q   <= buf_cnt_d;
         inflight_q  <= inflight_d;
      end
   end

endmodule

// File: tb/tb_iob_fifo2axis.sv
// Testbench for iob_fifo2axis: behavioural FIFO feeding the DUT, a negedge
// monitor collecting accepted words, and one task per scenario.
module tb_iob_fifo2axis;
   localparam int DW = 32;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          arst = 1'b0;
   logic          cke = 1'b1;
   logic          srst = 1'b0;
   logic          en = 1'b0;
   logic [LW-1:0] len = '0;
   logic          fifo_r_en;
   logic [DW-1:0] fifo_r_data = '0;
   logic          fifo_empty = 1'b1;
   logic          tvalid;
   logic [DW-1:0] tdata;
   logic          tready = 1'b1;
   logic          tlast;
   logic          busy;
   logic          done;

   iob_fifo2axis #(.DATA_W(DW), .LEN_W(LW)) dut (
      .clk_i(clk), .arst_i(arst), .cke_i(cke), .rst_i(srst),
      .en_i(en), .len_i(len),
      .fifo_r_en_o(fifo_r_en), .fifo_r_data_i(fifo_r_data), .fifo_empty_i(fifo_empty),
      .axis_tvalid_o(tvalid), .axis_tdata_o(tdata), .axis_tready_i(tready),
      .axis_tlast_o(tlast), .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference: fq is the FIFO contents, exp_q every word pushed this test
   logic [DW-1:0] fq[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_d[$];
   logic          got_l[$];
   logic          got_done[$];
   int n_reads, n_hs, max_out, stall_viol, empty_reads, done_cnt, underflow;
   logic          ren_s = 1'b0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_last;
   int tready_mode = 0;
   int cc = 0;

   // FIFO model: registered read data and registered empty flag
   always @(posedge clk) begin
      if (ren_s) begin
         if (fq.size() == 0) underflow++;
         else fifo_r_data <= fq.pop_front();
      end
      fifo_empty <= (fq.size() == 0);
   end

   // monitor samples on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (arst) begin
         ren_s = 1'b0;
         prev_stall = 1'b0;
      end else begin
         ren_s = fifo_r_en;
         if (fifo_r_en) begin
            n_reads++;
            if (fifo_empty) empty_reads++;
         end
         if (prev_stall && (!tvalid || tdata !== prev_data || tlast !== prev_last))
            stall_viol++;
         if (tvalid && tready && cke) begin
            got_d.push_back(tdata);
            got_l.push_back(tlast);
            got_done.push_back(done);
            n_hs++;
         end
         if (done) done_cnt++;
         if (n_reads - n_hs > max_out) max_out = n_reads - n_hs;
         prev_stall = tvalid && !tready;
         prev_data  = tdata;
         prev_last  = tlast;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cc++;
         case (tready_mode)
            0: tready = 1'b1;
            1: tready = (cc % 3 == 0);
            default: tready = 1'($urandom_range(0, 1));
         endcase
      end
   endtask

   task automatic clear_mon;
      got_d.delete(); got_l.delete(); got_done.delete(); exp_q.delete();
      n_reads = 0; n_hs = 0; max_out = 0; stall_viol = 0;
      empty_reads = 0; done_cnt = 0; underflow = 0;
   endtask

   task automatic push(input logic [DW-1:0] d);
      fq.push_back(d);
      exp_q.push_back(d);
   endtask

   task automatic start(input int l);
      en  = 1'b1;
      len = LW'(l);
   endtask

   // bounded wait for done; stops the request as soon as done has been seen
   task automatic wait_done(input int budget, output int used);
      used = 0;
      while (done_cnt == 0 && used < budget) begin
         cyc(1);
         used++;
      end
      en = 1'b0;
      len = '0;
      if (done_cnt == 0) begin
         errors++;
         $display("FAIL wait_done timeout: done not seen within %0d cycles", budget);
         arst = 1'b1; #1; arst = 1'b0;
      end
   endtask

   task automatic test_reset;
      arst = 1'b1;
      #1;
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", tvalid); end
      checks++; if (tdata !== '0) begin errors++; $display("FAIL reset_tdata got=%h exp=0", tdata); end
      checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b exp=0", tlast); end
      checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL reset_ren got=%b exp=0", fifo_r_en); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
      cyc(2);
      arst = 1'b0;
      cyc(2);
   endtask

   task automatic test_basic;
      int used, bad;
      tready_mode = 0;
      clear_mon();
      for (int i = 0; i < 4; i++) push(DW'(32'hA0 + i));
      cyc(1);
      start(4);
      cyc(2);
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL basic_early_tvalid got=%b exp=0", tvalid); end
      cyc(1);
      checks++; if (tvalid !== 1'b1 || tdata !== DW'(32'hA0)) begin errors++; $display("FAIL basic_first_word got=%b/%h exp=1/a0", tvalid, tdata); end
      wait_done(20, used);
      checks++; if (used != 4) begin errors++; $display("FAIL basic_rate got=%0d cycles exp=4", used); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got=%b exp=0", busy); end
      cyc(3);
      checks++; if (n_reads != 4 || done_cnt != 1) begin errors++; $display("FAIL basic_reads_done got=%0d/%0d exp=4/1", n_reads, done_cnt); end
      bad = 0;
      if (got_d.size() != 4) bad = 1;
      else for (int i = 0; i < 4; i++)
         if (got_d[i] !== exp_q[i] || got_l[i] !== (i == 3) || got_done[i] !== (i == 3)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL basic_stream got=%0d words %0d bad exp=4 words 0 bad", got_d.size(), bad); end
   endtask

   task automatic test_backpressure;
      int used, bad;
      tready_mode = 1;
      clear_mon();
      for (int i = 0; i < 10; i++) push($urandom);
      cyc(1);
      start(8);
      wait_done(200, used);
      tready_mode = 0;
      cyc(3);
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got=%0d violations exp=0", stall_viol); end
      checks++; if (max_out > 2) begin errors++; $display("FAIL bp_outstanding got=%0d exp<=2", max_out); end
      checks++; if (fq.size() != 2 || n_reads != 8) begin errors++; $display("FAIL bp_fifo_level got=%0d/%0d reads exp=2/8", fq.size(), n_reads); end
      bad = 0;
      if (got_d.size() != 8) bad = 1;
      else for (int i = 0; i < 8; i++)
         if (got_d[i] !== exp_q[i] || got_l[i] !== (i == 7) || got_done[i] !== (i == 7)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_stream got=%0d words %0d bad exp=8 words 0 bad", got_d.size(), bad); end
      fq.delete();
      cyc(2);
   endtask

   task automatic test_empty_stall;
      int used, bad;
      tready_mode = 0;
      clear_mon();
      for (int i = 0; i < 3; i++) push($urandom);
      cyc(1);
      start(6);
      cyc(10);
      checks++; if (tvalid !== 1'b0 || got_d.size() != 3) begin errors++; $display("FAIL stall_gap got=%b/%0d exp=0/3", tvalid, got_d.size()); end
      for (int i = 0; i < 3; i++) push($urandom);
      wait_done(40, used);
      cyc(2);
      checks++; if (empty_reads != 0 || underflow != 0) begin errors++; $display("FAIL stall_empty_read got=%0d/%0d exp=0/0", empty_reads, underflow); end
      bad = 0;
      if (got_d.size() != 6) bad = 1;
      else for (int i = 0; i < 6; i++)
         if (got_d[i] !== exp_q[i] || got_l[i] !== (i == 5)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL stall_stream got=%0d words %0d bad exp=6 words 0 bad", got_d.size(), bad); end
   endtask

   task automatic test_en_pause;
      int used, bad, k;
      tready_mode = 0;
      clear_mon();
      for (int i = 0; i < 5; i++) push($urandom);
      cyc(1);
      start(5);
      k = 0;
      while (n_reads < 2 && k < 20) begin cyc(1); k++; end
      en = 1'b0;
      cyc(5);
      checks++; if (n_reads != 2 || got_d.size() != 2 || busy !== 1'b1) begin errors++; $display("FAIL pause_state got=%0d reads %0d words busy=%b exp=2 2 1", n_reads, got_d.size(), busy); end
      en = 1'b1;
      wait_done(30, used);
      cyc(2);
      bad = 0;
      if (got_d.size() != 5) bad = 1;
      else for (int i = 0; i < 5; i++)
         if (got_d[i] !== exp_q[i] || got_l[i] !== (i == 4)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL pause_stream got=%0d words %0d bad exp=5 words 0 bad", got_d.size(), bad); end
   endtask

   task automatic test_len0_reset;
      int used, bad, k;
      tready_mode = 0;
      clear_mon();
      en = 1'b1; len = '0;
      cyc(5);
      checks++; if (n_reads != 0 || busy !== 1'b0 || done_cnt != 0) begin errors++; $display("FAIL len0 got=%0d reads busy=%b done=%0d exp=0 0 0", n_reads, busy, done_cnt); end
      en = 1'b0;
      for (int i = 0; i < 4; i++) push($urandom);
      cyc(1);
      start(4);
      k = 0;
      while (n_hs < 2 && k < 20) begin cyc(1); k++; end
      arst = 1'b1;
      en = 1'b0;
      #1;
      checks++; if ({tvalid, tlast, fifo_r_en, busy, done} !== 5'b0 || tdata !== '0) begin errors++; $display("FAIL arst_mid got=%b%b%b%b%b/%h exp=00000/0", tvalid, tlast, fifo_r_en, busy, done, tdata); end
      cyc(2);
      arst = 1'b0;
      fq.delete();
      cyc(2);
      clear_mon();
      push($urandom); push($urandom);
      cyc(1);
      start(2);
      wait_done(20, used);
      cyc(2);
      bad = 0;
      if (got_d.size() != 2) bad = 1;
      else for (int i = 0; i < 2; i++)
         if (got_d[i] !== exp_q[i] || got_l[i] !== (i == 1)) bad++;
      checks++; if (bad != 0 || done_cnt != 1) begin errors++; $display("FAIL post_reset_stream got=%0d words %0d bad %0d done exp=2 0 1", got_d.size(), bad, done_cnt); end
   endtask

   task automatic test_cke;
      int used, bad, k, r0, h0;
      tready_mode = 0;
      clear_mon();
      for (int i = 0; i < 8; i++) push($urandom);
      cyc(1);
      start(8);
      k = 0;
      while (n_hs < 3 && k < 20) begin cyc(1); k++; end
      cke = 1'b0;
      r0 = n_reads; h0 = n_hs;
      cyc(3);
      checks++; if (n_reads != r0 || n_hs != h0 || busy !== 1'b1) begin errors++; $display("FAIL cke_hold got=%0d/%0d exp=%0d/%0d", n_reads, n_hs, r0, h0); end
      cke = 1'b1;
      wait_done(30, used);
      cyc(2);
      bad = 0;
      if (got_d.size() != 8) bad = 1;
      else for (int i = 0; i < 8; i++)
         if (got_d[i] !== exp_q[i] || got_l[i] !== (i == 7)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL cke_stream got=%0d words %0d bad exp=8 words 0 bad", got_d.size(), bad); end
   endtask

   task automatic test_random;
      int used, bad, l, k;
      for (int it = 0; it < 6; it++) begin
         tready_mode = 2;
         clear_mon();
         l = $urandom_range(1, 12);
         k = $urandom_range(0, l);
         for (int i = 0; i < k; i++) push($urandom);
         cyc(1);
         start(l);
         cyc($urandom_range(0, 8));
         for (int i = k; i < l; i++) push($urandom);
         wait_done(300, used);
         tready_mode = 0;
         cyc(3);
         bad = 0;
         if (got_d.size() != l) bad = 1;
         else for (int i = 0; i < l; i++)
            if (got_d[i] !== exp_q[i] || got_l[i] !== (i == l - 1) || got_done[i] !== (i == l - 1)) bad++;
         if (stall_viol != 0 || max_out > 2 || empty_reads != 0 || underflow != 0 || n_reads != l) bad++;
         checks++; if (bad != 0) begin errors++; $display("FAIL random_%0d got=%0d words %0d bad len=%0d", it, got_d.size(), bad, l); end
      end
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_basic();
      test_backpressure();
      test_empty_stall();
      test_en_pause();
      test_len0_reset();
      test_cke();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
